// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
// Holds the deserializer FSM encoding and the parity-type helper.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Parity bit the transmitter should have sent, given the XOR of the data bits.
    function automatic logic par_expected(input logic acc, input logic typ);
        logic exp_bit;
        exp_bit = acc;
        case (typ)
            PAR_EVEN: exp_bit = acc;
            PAR_ODD:  exp_bit = ~acc;
            default:  exp_bit = acc;
        endcase
        return exp_bit;
    endfunction

endpackage

// File: rtl/uart_rx_par_acc.sv
// Running parity accumulator for one RX frame plus the parity-bit comparison.
// perr stays set from the parity check until the next clear.
module uart_rx_par_acc
    import uart_rx_pkg::*;
(
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic bit_en,
    input  logic bit_in,
    input  logic par_typ,
    input  logic chk_en,
    input  logic par_bit,
    output logic perr
);

    logic acc_q;
    logic perr_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            acc_q  <= 1'b0;
            perr_q <= 1'b0;
        end else if (clr) begin
            acc_q  <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            if (bit_en) begin
                acc_q <= acc_q ^ bit_in;
            end
            if (chk_en) begin
                perr_q <= (par_bit != par_expected(acc_q, par_typ));
            end
        end
    end

    assign perr = perr_q;

endmodule

// File: rtl/uart_rx_frame_deser.sv
// UART RX frame deserializer: assembles data bits, checks parity and stop bit,
// and presents a registered word with one-cycle valid / error pulses.
module uart_rx_frame_deser
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  sampled_bit,
    input  logic                  bit_valid,
    input  logic                  start_det,
    input  logic                  deser_clr,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy
);

    localparam int               CNT_W    = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    rx_state_e             state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [DATA_WIDTH-1:0] sh_q;
    logic [DATA_WIDTH-1:0] sh_d;
    logic [DATA_WIDTH-1:0] p_data_q;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  data_valid_q;
    logic                  par_err_q;
    logic                  stp_err_q;
    logic                  busy_q;

    logic                  frame_start;
    logic                  acc_clr;
    logic                  acc_bit_en;
    logic                  acc_chk_en;
    logic                  perr;

    assign frame_start = (state_q == ST_IDLE) && start_det;
    assign acc_clr     = deser_clr || frame_start;
    assign acc_bit_en  = !deser_clr && bit_valid && (state_q == ST_DATA);
    assign acc_chk_en  = !deser_clr && bit_valid && (state_q == ST_PARITY);

    if (MSB_FIRST) begin : g_msb_first
        assign sh_d = {sh_q[DATA_WIDTH-2:0], sampled_bit};
    end else begin : g_lsb_first
        assign sh_d = {sampled_bit, sh_q[DATA_WIDTH-1:1]};
    end

    uart_rx_par_acc u_par_acc (
        .CLK     (CLK),
        .RST     (RST),
        .clr     (acc_clr),
        .bit_en  (acc_bit_en),
        .bit_in  (sampled_bit),
        .par_typ (par_typ_q),
        .chk_en  (acc_chk_en),
        .par_bit (sampled_bit),
        .perr    (perr)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            sh_q         <= '0;
            p_data_q     <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            // Status outputs are single-cycle pulses unless re-asserted below.
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;

            if (deser_clr) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                sh_q    <= '0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start_det) begin
                            state_q   <= ST_DATA;
                            cnt_q     <= '0;
                            sh_q      <= '0;
                            par_en_q  <= PAR_EN;
                            par_typ_q <= PAR_TYP;
                            busy_q    <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        if (bit_valid) begin
                            sh_q  <= sh_d;
                            cnt_q <= cnt_q + 1'b1;
                            if (cnt_q == LAST_BIT) begin
                                state_q <= par_en_q ? ST_PARITY : ST_STOP;
                            end
                        end
                    end
                    ST_PARITY: begin
                        if (bit_valid) begin
                            state_q <= ST_STOP;
                        end
                    end
                    ST_STOP: begin
                        if (bit_valid) begin
                            state_q   <= ST_IDLE;
                            busy_q    <= 1'b0;
                            par_err_q <= perr;
                            stp_err_q <= !sampled_bit;
                            if (sampled_bit && !perr) begin
                                p_data_q     <= sh_q;
                                data_valid_q <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign P_DATA     = p_data_q;
    assign data_valid = data_valid_q;
    assign par_err    = par_err_q;
    assign stp_err    = stp_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_frame_deser.sv
// Self-checking bench for uart_rx_frame_deser: an 8-bit LSB-first and a 7-bit
// MSB-first instance, each frame's expected outcome queued and matched on output pulses.
module tb_uart_rx_frame_deser;

    logic       clk;
    logic       rst_n;
    logic [1:0] sampled_bit;
    logic [1:0] bit_valid;
    logic [1:0] start_det;
    logic [1:0] deser_clr;
    logic [1:0] par_en;
    logic [1:0] par_typ;
    logic [7:0] pdata0;
    logic [6:0] pdata1;
    logic [1:0] dv;
    logic [1:0] pe;
    logic [1:0] se;
    logic [1:0] busy;
    logic [8:0] pdata_w [2];

    typedef struct {
        int         dut;
        logic       dv;
        logic       pe;
        logic       se;
        logic [8:0] pdata;
    } exp_t;

    exp_t       exp_q[$];
    logic [8:0] exp_pdata [2];
    int         n_cmp = 0;
    int         n_err = 0;

    uart_rx_frame_deser #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) u_dut8 (
        .CLK         (clk),
        .RST         (rst_n),
        .sampled_bit (sampled_bit[0]),
        .bit_valid   (bit_valid[0]),
        .start_det   (start_det[0]),
        .deser_clr   (deser_clr[0]),
        .PAR_EN      (par_en[0]),
        .PAR_TYP     (par_typ[0]),
        .P_DATA      (pdata0),
        .data_valid  (dv[0]),
        .par_err     (pe[0]),
        .stp_err     (se[0]),
        .busy        (busy[0])
    );

    uart_rx_frame_deser #(.DATA_WIDTH(7), .MSB_FIRST(1'b1)) u_dut7 (
        .CLK         (clk),
        .RST         (rst_n),
        .sampled_bit (sampled_bit[1]),
        .bit_valid   (bit_valid[1]),
        .start_det   (start_det[1]),
        .deser_clr   (deser_clr[1]),
        .PAR_EN      (par_en[1]),
        .PAR_TYP     (par_typ[1]),
        .P_DATA      (pdata1),
        .data_valid  (dv[1]),
        .par_err     (pe[1]),
        .stp_err     (se[1]),
        .busy        (busy[1])
    );

    assign pdata_w[0] = {1'b0, pdata0};
    assign pdata_w[1] = {2'b00, pdata1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Pulses are matched against the queue in the cycle they appear; a pulse
    // with nothing queued (extra, stretched or spurious) is an error.
    always @(negedge clk) begin : monitor
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (rst_n && (dv[d] || pe[d] || se[d])) begin
                if (exp_q.size() == 0 || exp_q[0].dut != d) begin
                    check($sformatf("unexpected_pulse%0d", d), {29'd0, dv[d], pe[d], se[d]}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("sb_dv%0d", d), dv[d], e.dv);
                    check($sformatf("sb_pe%0d", d), pe[d], e.pe);
                    check($sformatf("sb_se%0d", d), se[d], e.se);
                    check($sformatf("sb_pdata%0d", d), pdata_w[d], e.pdata);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic par_of(input logic [8:0] v, input int w);
        logic p;
        p = 1'b0;
        for (int i = 0; i < w; i++) p ^= v[i];
        return p;
    endfunction

    task automatic send_bit(input int d, input logic b);
        sampled_bit[d] = b;
        bit_valid[d]   = 1'b1;
        tick();
        bit_valid[d]   = 1'b0;
        tick();
    endtask

    // inject_kind 0: extra start_det after data bit inject_at; 1: flip PAR_EN/PAR_TYP there.
    task automatic send_frame(input int d, input int w, input bit msb, input logic [8:0] data,
                              input bit pen, input bit ptyp, input bit pb, input bit stop,
                              input bit coincide = 1'b0, input int inject_at = -1,
                              input int inject_kind = 0);
        exp_t       e;
        logic       exp_perr;
        logic [8:0] mask;
        mask       = 9'((1 << w) - 1);
        par_en[d]  = pen;
        par_typ[d] = ptyp;
        start_det[d] = 1'b1;
        if (coincide) begin
            sampled_bit[d] = 1'b1;
            bit_valid[d]   = 1'b1;
        end
        tick();
        start_det[d] = 1'b0;
        bit_valid[d] = 1'b0;
        check($sformatf("busy_rise%0d", d), busy[d], 1'b1);
        for (int i = 0; i < w; i++) begin
            send_bit(d, msb ? data[w-1-i] : data[i]);
            if (i == inject_at) begin
                if (inject_kind == 0) begin
                    start_det[d] = 1'b1;
                    tick();
                    start_det[d] = 1'b0;
                end else begin
                    par_en[d]  = ~par_en[d];
                    par_typ[d] = ~par_typ[d];
                end
            end
        end
        exp_perr = pen && (pb != (par_of(data & mask, w) ^ ptyp));
        if (pen) send_bit(d, pb);
        if (!exp_perr && stop) exp_pdata[d] = data & mask;
        e.dut   = d;
        e.dv    = !exp_perr && stop;
        e.pe    = exp_perr;
        e.se    = !stop;
        e.pdata = exp_pdata[d];
        exp_q.push_back(e);
        sampled_bit[d] = stop;
        bit_valid[d]   = 1'b1;
        tick();
        bit_valid[d]   = 1'b0;
        check($sformatf("stop_dv%0d", d), dv[d], e.dv);
        check($sformatf("stop_pe%0d", d), pe[d], e.pe);
        check($sformatf("stop_se%0d", d), se[d], e.se);
        check($sformatf("busy_fall%0d", d), busy[d], 1'b0);
    endtask

    task automatic settle();
        tick();
        tick();
        check("pending", exp_q.size(), 32'd0);
        for (int d = 0; d < 2; d++) check($sformatf("pdata_hold%0d", d), pdata_w[d], exp_pdata[d]);
    endtask

    initial begin
        rst_n       = 1'b0;
        sampled_bit = '0;
        bit_valid   = '0;
        start_det   = '0;
        deser_clr   = '0;
        par_en      = '0;
        par_typ     = '0;
        exp_pdata[0] = '0;
        exp_pdata[1] = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("rst_pdata%0d", d), pdata_w[d], 9'd0);
            check($sformatf("rst_dv%0d", d), dv[d], 1'b0);
            check($sformatf("rst_pe%0d", d), pe[d], 1'b0);
            check($sformatf("rst_se%0d", d), se[d], 1'b0);
            check($sformatf("rst_busy%0d", d), busy[d], 1'b0);
        end
        rst_n = 1'b1;
        tick();

        send_frame(0, 8, 1'b0, 9'h0A5, 1'b1, 1'b0, 1'b0, 1'b1); settle();
        send_frame(0, 8, 1'b0, 9'h0A5, 1'b1, 1'b0, 1'b1, 1'b1); settle();
        send_frame(0, 8, 1'b0, 9'h03C, 1'b0, 1'b0, 1'b0, 1'b0); settle();
        send_frame(0, 8, 1'b0, 9'h081, 1'b0, 1'b0, 1'b0, 1'b1); settle();
        send_frame(0, 8, 1'b0, 9'h05A, 1'b1, 1'b1, 1'b0, 1'b0); settle();
        send_frame(1, 7, 1'b1, 9'h065, 1'b1, 1'b1, 1'b1, 1'b1); settle();
        send_frame(1, 7, 1'b1, 9'h02A, 1'b0, 1'b0, 1'b0, 1'b1); settle();

        // Abort after four data bits; nothing may come out of the partial frame.
        par_en[0]    = 1'b0;
        start_det[0] = 1'b1;
        tick();
        start_det[0] = 1'b0;
        for (int i = 0; i < 4; i++) send_bit(0, 1'b1);
        deser_clr[0] = 1'b1;
        tick();
        deser_clr[0] = 1'b0;
        check("clr_busy", busy[0], 1'b0);
        settle();
        send_frame(0, 8, 1'b0, 9'h055, 1'b0, 1'b0, 1'b0, 1'b1); settle();

        send_frame(0, 8, 1'b0, 9'h0C3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3, 0); settle();
        send_frame(0, 8, 1'b0, 9'h096, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2, 1); settle();
        send_frame(0, 8, 1'b0, 9'h096, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2, 1); settle();

        send_bit(0, 1'b0);
        send_frame(0, 8, 1'b0, 9'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1); settle();

        send_frame(0, 8, 1'b0, 9'h012, 1'b1, 1'b0, 1'b0, 1'b1);
        send_frame(0, 8, 1'b0, 9'h034, 1'b1, 1'b0, 1'b1, 1'b1); settle();

        // Asynchronous reset in the middle of a frame.
        par_en[0]    = 1'b0;
        start_det[0] = 1'b1;
        tick();
        start_det[0] = 1'b0;
        for (int i = 0; i < 3; i++) send_bit(0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        exp_pdata[0] = '0;
        exp_pdata[1] = '0;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("midrst_pdata%0d", d), pdata_w[d], 9'd0);
            check($sformatf("midrst_busy%0d", d), busy[d], 1'b0);
            check($sformatf("midrst_flags%0d", d), {dv[d], pe[d], se[d]}, 3'b000);
        end
        tick();
        rst_n = 1'b1;
        tick();
        send_frame(0, 8, 1'b0, 9'h0E7, 1'b0, 1'b0, 1'b0, 1'b1); settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_deser.md
# uart_rx_frame_deser

Parametrised receive-side frame deserializer for the UART RX path. It sits between the bit-sampling logic and the RX controller. It consumes one sampled bit per `bit_valid` strobe and tracks frame position internally, so no external bit counter is needed. It assembles `DATA_WIDTH` data bits in a selectable bit order, checks optional parity and the stop bit, and presents a registered word with a one-cycle valid pulse and error flags.

## Interface
- `DATA_WIDTH`, 8: data bits per frame; legal range 5..9.
- `MSB_FIRST`, 0: 0 = first received data bit lands in `P_DATA[0]`; 1 = first received bit lands in `P_DATA[DATA_WIDTH-1]`.
- `CLK` in 1: single clock, all logic on the rising edge.
- `RST` in 1: asynchronous, active-low reset.
- `sampled_bit` in 1: majority-voted bit value; valid only when `bit_valid`=1.
- `bit_valid` in 1: one-cycle strobe, one per bit period (data, parity and stop bits only).
- `start_det` in 1: one-cycle pulse when a start bit is confirmed.
- `deser_clr` in 1: synchronous abort; discards any frame in progress.
- `PAR_EN` in 1: parity bit present.
- `PAR_TYP` in 1: 0 = even, 1 = odd.
- `P_DATA` out `DATA_WIDTH`: last error-free received word.
- `data_valid` out 1: one-cycle pulse when `P_DATA` is updated.
- `par_err` out 1: one-cycle pulse on parity mismatch.
- `stp_err` out 1: one-cycle pulse when the stop bit is 0.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, DATA, PARITY, STOP.
- IDLE:
  - `start_det`=1 → DATA. On the same edge: clear the bit counter, shift register and parity accumulator; latch `PAR_EN`/`PAR_TYP` into frame-config registers.
  - `bit_valid` in IDLE is ignored.
- DATA:
  - Each `bit_valid` shifts `sampled_bit` in and XORs it into the accumulator.
  - `MSB_FIRST`=0: `{sampled_bit, sh[W-1:1]}`. `MSB_FIRST`=1: `{sh[W-2:0], sampled_bit}`.
  - The counter (width `$clog2(DATA_WIDTH+1)`) increments per bit.
  - On the `DATA_WIDTH`-th bit: → PARITY if the latched `PAR_EN`=1, else → STOP.
- PARITY:
  - On `bit_valid`: expected = acc XOR latched `PAR_TYP`. Mismatch with `sampled_bit` sets the internal `perr` flag. → STOP.
- STOP:
  - On `bit_valid`: → IDLE.
  - If `sampled_bit`=1 and no `perr`: load `P_DATA` from the shift register and pulse `data_valid`.
  - Otherwise `P_DATA` holds and `data_valid` stays 0. `par_err` pulses if `perr`; `stp_err` pulses if the stop bit is 0. Both may pulse together.
- `start_det` outside IDLE is ignored; no re-sync mid-frame.
- `deser_clr` has priority over all other inputs: → IDLE next edge, counter/accumulator/`perr` cleared, no output pulses, `P_DATA` unchanged.
- Runtime changes to `PAR_EN`/`PAR_TYP` mid-frame have no effect until the next `start_det`.
- A new `start_det` is accepted in the first IDLE cycle after STOP, so back-to-back frames run with no gap.

## Timing
- Reset values: `P_DATA`=0, `data_valid`=0, `par_err`=0, `stp_err`=0, `busy`=0, FSM=IDLE. All internal registers also cleared.
- `busy` rises on the edge that samples `start_det` and falls on the edge that samples the stop-bit `bit_valid`.
- `data_valid`, `par_err`, `stp_err` and the new `P_DATA` appear on the edge that samples the stop-bit `bit_valid`, i.e. visible the following cycle.
- Pulses are exactly one cycle wide.
- If `start_det` and `bit_valid` are high in the same IDLE cycle, only the start is taken; the bit is not consumed.
- Reset asserted mid-frame: immediate return to reset values; the partial frame is lost.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared package `uart_rx_pkg`:
  - FSM state typedef (2-bit encoding: IDLE=0, DATA=1, PARITY=2, STOP=3).
  - `PAR_EVEN`=0, `PAR_ODD`=1 constants.
- Sub-module `uart_rx_par_acc` owns the parity accumulator and comparison.
  - Ports: `CLK`, `RST`, `clr`, `bit_en`, `bit_in`, `par_typ`, `chk_en`, `par_bit`, `perr`.
- The shift register, counter and FSM stay in the top module.

## Test plan
- `DATA_WIDTH`=8, `MSB_FIRST`=0, `PAR_EN`=1, even parity. Send 0xA5 LSB-first (1,0,1,0,0,1,0,1), parity 0, stop 1 → `P_DATA`=0xA5, `data_valid` pulse 1 cycle, no errors.
- Same frame with parity bit 1 → `par_err` pulse, `data_valid`=0, `P_DATA` keeps its previous value.
- `PAR_EN`=0, data 0x3C, stop bit 0 → `stp_err` pulse, no `data_valid`; a following good 0x81 frame → `P_DATA`=0x81.
- `MSB_FIRST`=1, `DATA_WIDTH`=7. Send bits 1,1,0,0,1,0,1, odd parity 1, stop 1 → `P_DATA`=7'h65, `data_valid` pulse.
- `deser_clr` after 4 data bits, then a full 0x55 frame → only one `data_valid`, with `P_DATA`=0x55.
- `start_det` pulsed in the middle of DATA and coincident with `bit_valid` in IDLE → mid-frame pulse ignored; coincident bit not shifted; `RST` low mid-frame → all outputs 0.
